// File: rtl/johnson_ctr_if.sv
// johnson_ctr_if: Johnson counter output bundle (state, phase index, illegal flag)
// out     - counter state, WIDTH bits
// phase   - index of current state, $clog2(2*WIDTH) bits
// illegal - high while out is not a Johnson pattern
interface johnson_ctr_if #(parameter int WIDTH = 4);
   localparam int PW = $clog2(2 * WIDTH);
   logic [WIDTH-1:0] out;
   logic [PW-1:0]    phase;
   logic             illegal;
   modport master (output out, phase, illegal);
   modport slave  (input out, phase, illegal);
endinterface

// File: rtl/johnson_ctr.sv
// johnson_ctr: self-correcting WIDTH-bit Johnson counter with phase decode
// clk  - rising-edge clock
// rstn - synchronous reset, active high (rstn=1 clears the counter)
// bus  - master side of johnson_ctr_if: out, phase, illegal
module johnson_ctr #(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          rstn,
   johnson_ctr_if.master bus
);
   localparam int PW = $clog2(2 * WIDTH);
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] cur;
   logic [PW-1:0]    ones;
   logic             legal;
   assign bus.out = q;
   // decode and next state read the visible output so an upset on it is seen and corrected
   assign cur = bus.out;
   always_comb begin
      legal       = $countones(cur[WIDTH-1:1] ^ cur[WIDTH-2:0]) <= 1;
      ones        = PW'($countones(cur));
      // 2*WIDTH may wrap to 0 at PW bits; the subtraction is still correct modulo 2^PW
      bus.phase   = !legal ? '0 : cur[0] ? PW'(2 * WIDTH) - ones : ones;
      bus.illegal = !legal;
   end
   always_ff @(posedge clk) begin
      if (rstn || !legal) q <= '0;
      else q <= {~cur[0], cur[WIDTH-1:1]};
   end
endmodule

// File: tb/tb_johnson_ctr.sv
// tb_johnson_ctr: randomized and directed check of johnson_ctr at WIDTH 2, 4 and 8
module tb_johnson_ctr;
   logic clk = 1'b0;
   logic rstn = 1'b1;
   int   nchk = 0;
   int   nfail = 0;
   int   p2 = 0, p4 = 0, p8 = 0;
   bit   frc4 = 1'b0;
   always #5 clk = ~clk;
   johnson_ctr_if #(.WIDTH(2)) i2 ();
   johnson_ctr_if #(.WIDTH(4)) i4 ();
   johnson_ctr_if #(.WIDTH(8)) i8 ();
   johnson_ctr #(.WIDTH(2)) u2 (.clk(clk), .rstn(rstn), .bus(i2.master));
   johnson_ctr #(.WIDTH(4)) u4 (.clk(clk), .rstn(rstn), .bus(i4.master));
   johnson_ctr #(.WIDTH(8)) u8 (.clk(clk), .rstn(rstn), .bus(i8.master));
   // state at phase p: first p bits filled with ones from the MSB, then drained from the MSB
   function automatic logic [7:0] jpat(int w, int p);
      if (p <= w) return 8'(((1 << p) - 1) << (w - p));
      return 8'((1 << (2 * w - p)) - 1);
   endfunction
   task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
      nchk++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic check_all();
      chk("w2_out", 8'(i2.out), jpat(2, p2));
      chk("w2_phase", 8'(i2.phase), 8'(p2));
      chk("w2_illegal", 8'(i2.illegal), 8'd0);
      chk("w4_out", 8'(i4.out), jpat(4, p4));
      chk("w4_phase", 8'(i4.phase), 8'(p4));
      chk("w4_illegal", 8'(i4.illegal), 8'd0);
      chk("w8_out", 8'(i8.out), jpat(8, p8));
      chk("w8_phase", 8'(i8.phase), 8'(p8));
      chk("w8_illegal", 8'(i8.illegal), 8'd0);
   endtask
   task automatic step(bit r);
      rstn = r;
      @(posedge clk);
      p2 = r ? 0 : (p2 + 1) % 4;
      p4 = (r || frc4) ? 0 : (p4 + 1) % 8;
      p8 = r ? 0 : (p8 + 1) % 16;
      #1;
      if (frc4) begin
         release i4.out;
         frc4 = 1'b0;
      end
      @(negedge clk);
      check_all();
   endtask
   initial begin
      @(negedge clk);
      step(1'b1);
      step(1'b1);
      for (int i = 0; i < 15; i++) step(1'b0);
      while (p4 != 3) step(1'b0);
      step(1'b1);
      chk("midreset_out", 8'(i4.out), 8'h00);
      step(1'b0);
      chk("after_midreset", 8'(i4.out), 8'h08);
      for (int i = 0; i < 3; i++) step(1'b0);
      force i4.out = 4'b0101;
      frc4 = 1'b1;
      #1;
      chk("forced_illegal", 8'(i4.illegal), 8'd1);
      chk("forced_phase", 8'(i4.phase), 8'd0);
      step(1'b0);
      chk("recovered_out", 8'(i4.out), 8'h00);
      step(1'b0);
      chk("resume_out", 8'(i4.out), 8'h08);
      step(1'b0);
      force i4.out = 4'b1011;
      frc4 = 1'b1;
      #1;
      chk("forced2_illegal", 8'(i4.illegal), 8'd1);
      step(1'b1);
      chk("reset_beats_fix", 8'(i4.out), 8'h00);
      for (int i = 0; i < 20; i++) step(1'b0);
      for (int i = 0; i < 80; i++) step($urandom_range(0, 9) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
